uart_rx_parity_unit: RTL and testbench

Parametrised parity engine for the UART receive path, sitting between the data sampler and the RX control FSM. It accumulates parity over a configurable-length data field as sampled bits arrive, then checks the received parity bit against even, odd, mark or space parity. It reports a per-frame result with a done strobe and, optionally, a saturating error count.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_parity_unit_if.sv | 31 +++
 rtl/uart_err_counter.sv | 24 ++
 rtl/uart_rx_parity_unit.sv | 114 +++++++++++
 tb/tb_uart_rx_parity_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive parity path: parity type and
// engine state encodings, minimum data length, and expected-parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10
  } state_e;

  localparam int MIN_DATA_LEN = 5;

  // Expected parity bit given the XOR of all data bits.
  function automatic logic exp_parity(input logic acc, input par_typ_e typ);
    case (typ)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_parity_unit_if.sv
// Bus between the RX sampler/control FSM (master) and the parity engine (slave).
// Handshake: frame_start and bit_valid are single-cycle strobes with no back-pressure;
// par_done is a single-cycle result strobe qualifying par_err/par_calc.
interface uart_rx_parity_unit_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  localparam int LEN_W = $clog2(DATA_W + 1);

  logic             frame_start;
  logic             bit_valid;
  logic             sampled_bit;
  logic             par_en;
  logic [1:0]       par_typ;
  logic [LEN_W-1:0] data_len;
  logic             clr_cnt;
  logic             par_calc;
  logic             par_done;
  logic             par_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output frame_start, bit_valid, sampled_bit, par_en, par_typ, data_len, clr_cnt,
    input  par_calc, par_done, par_err, err_cnt
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit, par_en, par_typ, data_len, clr_cnt,
    output par_calc, par_done, par_err, err_cnt
  );
endinterface

// File: rtl/uart_err_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module uart_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_rx_parity_unit.sv
// UART RX parity engine: accumulates data-bit parity and checks the parity bit.
// Optional saturating error counter is built when PARITY_ERR_CNT_EN is defined.
module uart_rx_parity_unit
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_parity_unit_if.slave  bus,
  output state_e                state_o
);
  localparam int LEN_W = $clog2(DATA_W + 1);

  state_e           state_q;
  logic             acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             par_en_q;
  par_typ_e         typ_q;
  logic             par_calc_q;
  logic             done_q;
  logic             err_q;

  logic             acc_d;
  logic             last_bit;
  logic [LEN_W-1:0] len_clamp;

  assign acc_d    = acc_q ^ bus.sampled_bit;
  assign last_bit = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    len_clamp = bus.data_len;
    if (bus.data_len < LEN_W'(MIN_DATA_LEN)) begin
      len_clamp = LEN_W'(MIN_DATA_LEN);
    end else if (bus.data_len > LEN_W'(DATA_W)) begin
      len_clamp = LEN_W'(DATA_W);
    end
  end

  // frame_start restarts the engine from any state and masks a coincident bit_valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      len_q      <= LEN_W'(MIN_DATA_LEN);
      par_en_q   <= 1'b0;
      typ_q      <= PAR_EVEN;
      par_calc_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.frame_start) begin
        state_q  <= ST_DATA;
        acc_q    <= 1'b0;
        cnt_q    <= '0;
        err_q    <= 1'b0;
        par_en_q <= bus.par_en;
        typ_q    <= par_typ_e'(bus.par_typ);
        len_q    <= len_clamp;
      end else begin
        case (state_q)
          ST_DATA: begin
            if (bus.bit_valid) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + LEN_W'(1);
              if (last_bit) begin
                par_calc_q <= exp_parity(acc_d, typ_q);
                if (par_en_q) begin
                  state_q <= ST_PARITY;
                end else begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
                end
              end
            end
          end
          ST_PARITY: begin
            if (bus.bit_valid) begin
              err_q   <= (bus.sampled_bit != par_calc_q);
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_IDLE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.par_calc = par_calc_q;
  assign bus.par_done = done_q;
  assign bus.par_err  = err_q;
  assign state_o      = state_q;

`ifdef PARITY_ERR_CNT_EN
  uart_err_counter #(.CNT_W(CNT_W)) u_err_counter (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (bus.clr_cnt),
    .inc_i  (done_q & err_q),
    .cnt_o  (bus.err_cnt)
  );
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = bus.clr_cnt;
  assign bus.err_cnt    = '0;
`endif
endmodule

// File: tb/tb_uart_rx_parity_unit.sv
// Directed-vector bench for uart_rx_parity_unit with a queue-based result scoreboard.
module tb_uart_rx_parity_unit;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = $clog2(DATA_W + 1);

  logic   clk;
  logic   rst_n;
  state_e st;

  int checks = 0;
  int errors = 0;

  // {check_calc, exp_calc, exp_err}
  logic [2:0] exp_q[$];

  uart_rx_parity_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  uart_rx_parity_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .bus     (bus),
    .state_o (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic start_frame(input logic pen, input logic [1:0] typ,
                             input logic [LEN_W-1:0] dlen, input logic with_bit);
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    bus.bit_valid   = with_bit;
    bus.sampled_bit = 1'b1;
    bus.par_en      = pen;
    bus.par_typ     = typ;
    bus.data_len    = dlen;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.par_en      = ~pen;
    bus.par_typ     = ~typ;
    bus.data_len    = '0;
  endtask

  task automatic send_bit(input logic b);
    repeat ($urandom_range(0, 1)) @(posedge clk);
    #1;
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = b;
    @(posedge clk); #1;
    bus.bit_valid   = 1'b0;
    bus.sampled_bit = 1'b0;
  endtask

  task automatic frame_body(input logic [15:0] data, input int nbits, input logic pen,
                            input logic pbit, input logic exp_calc, input logic exp_err,
                            input logic clr_at_done);
    exp_q.push_back({pen, exp_calc, exp_err});
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    @(negedge clk);
    check("done_latency", {31'd0, bus.par_done}, 32'd1);
    if (clr_at_done) begin
      bus.clr_cnt = 1'b1;
      @(posedge clk); #1;
      bus.clr_cnt = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] data, input int nbits, input logic pen,
                            input logic [1:0] typ, input logic [LEN_W-1:0] dlen,
                            input logic pbit, input logic exp_calc, input logic exp_err);
    start_frame(pen, typ, dlen, 1'b0);
    frame_body(data, nbits, pen, pbit, exp_calc, exp_err, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst_n && bus.par_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got 1 want 0");
      end else begin
        e = exp_q.pop_front();
        check("par_err", {31'd0, bus.par_err}, {31'd0, e[0]});
        if (e[2]) check("par_calc", {31'd0, bus.par_calc}, {31'd0, e[1]});
      end
    end
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.sampled_bit = 1'b0;
    bus.par_en      = 1'b0;
    bus.par_typ     = 2'b00;
    bus.data_len    = '0;
    bus.clr_cnt     = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",    {30'd0, st},           {30'd0, ST_IDLE});
    check("rst_par_calc", {31'd0, bus.par_calc}, 32'd0);
    check("rst_par_done", {31'd0, bus.par_done}, 32'd0);
    check("rst_par_err",  {31'd0, bus.par_err},  32'd0);
    check("rst_err_cnt",  {24'd0, bus.err_cnt},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // bit_valid while idle must be ignored
    send_bit(1'b1);
    send_bit(1'b0);

    // even len8 0xA5: four ones -> calc 0
    send_frame(16'h00A5, 8, 1'b1, PAR_EVEN, 4'd8, 1'b0, 1'b0, 1'b0);
    // odd len7 0x15: three ones -> calc 0
    send_frame(16'h0015, 7, 1'b1, PAR_ODD, 4'd7, 1'b0, 1'b0, 1'b0);
    send_frame(16'h0015, 7, 1'b1, PAR_ODD, 4'd7, 1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("par_err_hold", {31'd0, bus.par_err}, 32'd1);
    // mark / space, len5, parity bit 0
    send_frame(16'h0000, 5, 1'b1, PAR_MARK,  4'd5, 1'b0, 1'b1, 1'b1);
    send_frame(16'h0000, 5, 1'b1, PAR_SPACE, 4'd5, 1'b0, 1'b0, 1'b0);
    // no parity, len8: done after 8th bit
    send_frame(16'h00FF, 8, 1'b0, PAR_ODD, 4'd8, 1'b0, 1'b0, 1'b0);
    // len3 clamps to 5: 0x1F has five ones, even -> calc 1
    send_frame(16'h001F, 5, 1'b1, PAR_EVEN, 4'd3, 1'b1, 1'b1, 1'b0);
    // len12 clamps to 8: 0x01 -> calc 1, parity bit 0 -> error
    send_frame(16'h0001, 8, 1'b1, PAR_EVEN, 4'd12, 1'b0, 1'b1, 1'b1);

    // abort after 4 bits, restart with a coincident (ignored) bit_valid
    start_frame(1'b1, PAR_ODD, 4'd8, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    start_frame(1'b1, PAR_EVEN, 4'd8, 1'b1);
    frame_body(16'h000F, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef PARITY_ERR_CNT_EN
    check("err_cnt_three", {24'd0, bus.err_cnt}, 32'd3);
`else
    check("err_cnt_off", {24'd0, bus.err_cnt}, 32'd0);
`endif

    // reset while waiting for the parity bit
    start_frame(1'b1, PAR_EVEN, 4'd5, 1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    check("in_parity", {30'd0, st}, {30'd0, ST_PARITY});
    check("calc_before_rst", {31'd0, bus.par_calc}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_state",    {30'd0, st},           {30'd0, ST_IDLE});
    check("mid_rst_par_calc", {31'd0, bus.par_calc}, 32'd0);
    check("mid_rst_par_done", {31'd0, bus.par_done}, 32'd0);
    check("mid_rst_par_err",  {31'd0, bus.par_err},  32'd0);
    check("mid_rst_err_cnt",  {24'd0, bus.err_cnt},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bit(1'b1);
    repeat (2) @(posedge clk);

`ifdef PARITY_ERR_CNT_EN
    for (int n = 0; n < 300; n++)
      send_frame(16'h0000, 5, 1'b1, PAR_MARK, 4'd5, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("err_cnt_sat", {24'd0, bus.err_cnt}, 32'd255);
    start_frame(1'b1, PAR_MARK, 4'd5, 1'b0);
    frame_body(16'h0000, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("err_cnt_clr", {24'd0, bus.err_cnt}, 32'd0);
    send_frame(16'h0000, 5, 1'b1, PAR_MARK, 4'd5, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("err_cnt_one", {24'd0, bus.err_cnt}, 32'd1);
`else
    send_frame(16'h0000, 5, 1'b1, PAR_MARK, 4'd5, 1'b0, 1'b1, 1'b1);
    bus.clr_cnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.clr_cnt = 1'b0;
    @(negedge clk);
    check("err_cnt_tied", {24'd0, bus.err_cnt}, 32'd0);
`endif

    // drain: every pushed expectation must have been matched
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
